// File: rtl/sf_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sf_fifo_pkg : shared types for the store-and-forward FIFO read side
// Revision    : 1.0
// ----------------------------------------------------------------------------
package sf_fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sf_rd_state_t;

  localparam int SF_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/sf_out_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sf_out_stage : valid/ready output register carrying data with sop/last
// Revision     : 1.0
// ----------------------------------------------------------------------------
module sf_out_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sop_i,
  input  logic                  last_i,
  input  logic                  m_ready_i,
  output logic                  can_load_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_sop_o,
  output logic                  m_last_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  last_q, last_d;

  assign can_load_o = !valid_q || m_ready_i;

  // A stalled word (valid & !ready) holds every field until it is accepted.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sop_d   = sop_i;
      last_d  = last_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      last_q  <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_sop_o   = sop_q;
  assign m_last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/sf_pkt_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sf_pkt_reader : pops a length descriptor, then that many data words,
//                 and streams them out with sop/last framing.
// Option        : SF_PKT_RD_STATS_EN builds packet/word statistics counters.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module sf_pkt_reader
  import sf_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  len_valid_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  len_ready_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_sop_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  len_err_o,
  output logic [31:0]           pkt_cnt_o,
  output logic [31:0]           word_cnt_o
);

  sf_rd_state_t     state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             sop_pend_q, sop_pend_d;
  logic             len_err_q, len_err_d;
  logic             can_load;
  logic             last_word;

  assign last_word   = (remaining_q == LEN_W'(1));
  assign len_ready_o = (state_q == IDLE) && len_valid_i;
  assign fifo_rden_o = (state_q == STREAM) && !fifo_empty_i && can_load;
  assign busy_o      = (state_q != IDLE);
  assign len_err_o   = len_err_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sop_pend_d  = sop_pend_q;
    len_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_valid_i) begin
          if (len_i == '0) begin
            len_err_d = 1'b1;
          end else begin
            remaining_d = len_i;
            sop_pend_d  = 1'b1;
            state_d     = STREAM;
          end
        end
      end
      STREAM: begin
        // remaining is at least 1 here, so the decrement cannot wrap.
        if (fifo_rden_o) begin
          sop_pend_d  = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if (last_word) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sop_pend_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sop_pend_q  <= sop_pend_d;
      len_err_q   <= len_err_d;
    end
  end

  sf_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (fifo_rden_o),
    .data_i     (fifo_rdata_i),
    .sop_i      (sop_pend_q),
    .last_i     (last_word),
    .m_ready_i  (m_ready_i),
    .can_load_o (can_load),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_sop_o    (m_sop_o),
    .m_last_o   (m_last_o)
  );

`ifdef SF_PKT_RD_STATS_EN
  logic [SF_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [SF_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                xfer;

  assign xfer = m_valid_o && m_ready_i;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    word_cnt_d = word_cnt_q;
    if (xfer && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + SF_CNT_W'(1);
    end
    if (xfer && m_last_o && (pkt_cnt_q != '1)) begin
      pkt_cnt_d = pkt_cnt_q + SF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign word_cnt_o = word_cnt_q;
`else
  assign pkt_cnt_o  = '0;
  assign word_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sf_pkt_reader.sv
`default_nettype none
// Directed bench for sf_pkt_reader with a queue-based model of the length
// queue and fall-through data FIFO.
module tb_sf_pkt_reader;

`ifdef SF_PKT_RD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic        sop;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        len_valid_i;
  logic [4:0]  len_i;
  logic        len_ready_o;
  logic        fifo_empty_i;
  logic [31:0] fifo_rdata_i;
  logic        fifo_rden_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_sop_o;
  logic        m_last_o;
  logic        m_ready_i;
  logic        busy_o;
  logic        len_err_o;
  logic [31:0] pkt_cnt_o;
  logic [31:0] word_cnt_o;

  always #5 clk = ~clk;

  sf_pkt_reader #(.DATA_WIDTH(32), .LEN_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .len_valid_i  (len_valid_i),
    .len_i        (len_i),
    .len_ready_o  (len_ready_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_sop_o      (m_sop_o),
    .m_last_o     (m_last_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o),
    .len_err_o    (len_err_o),
    .pkt_cnt_o    (pkt_cnt_o),
    .word_cnt_o   (word_cnt_o)
  );

  logic [31:0] dq[$];
  logic [4:0]  lq[$];
  beat_t       outq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          viol     = 0;
  int          len_pops = 0;

  logic        o_valid, o_sop, o_last, o_rden, o_lenr, o_busy, o_err, o_ready;
  logic [31:0] o_data, o_pkt, o_word;

  task automatic refresh();
    fifo_empty_i = (dq.size() == 0);
    fifo_rdata_i = (dq.size() != 0) ? dq[0] : 32'h0;
    len_valid_i  = (lq.size() != 0);
    len_i        = (lq.size() != 0) ? lq[0] : 5'd0;
  endtask

  // One clock: sample at the falling edge, then apply FIFO/queue pops just after the rising edge.
  task automatic tick();
    logic [31:0] dmy;
    logic [4:0]  lmy;
    @(negedge clk);
    o_valid = m_valid_o; o_data = m_data_o; o_sop = m_sop_o; o_last = m_last_o;
    o_rden = fifo_rden_o; o_lenr = len_ready_o; o_busy = busy_o; o_err = len_err_o;
    o_ready = m_ready_i; o_pkt = pkt_cnt_o; o_word = word_cnt_o;
    if (fifo_rden_o && fifo_empty_i) viol++;
    if (len_ready_o && busy_o) viol++;
    if (m_valid_o && m_ready_i && rst_n) outq.push_back({m_sop_o, m_last_o, m_data_o});
    @(posedge clk);
    #1;
    if (!rst_n) begin
      dq.delete();
      lq.delete();
    end else begin
      if (o_rden && dq.size() != 0) dmy = dq.pop_front();
      if (o_lenr && lq.size() != 0) begin
        lmy = lq.pop_front();
        len_pops++;
      end
    end
    refresh();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_ready_i = 1'b1;
    refresh();
    repeat (3) tick();
    n_checks++;
    if ({o_valid, o_sop, o_last, o_rden, o_lenr, o_busy, o_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {o_valid, o_sop, o_last, o_rden, o_lenr, o_busy, o_err});
    end
    n_checks++;
    if (o_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", o_data);
    end
    n_checks++;
    if ({o_pkt, o_word} !== 64'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_pkt, o_word);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [5:0] rh, vh, bh;
    beat_t exp_q[$];
    outq.delete();
    dq.push_back(32'hAAAA_000A); dq.push_back(32'hBBBB_000B); dq.push_back(32'hCCCC_000C);
    lq.push_back(5'd3);
    refresh();
    for (int i = 0; i < 6; i++) begin
      tick();
      rh[5-i] = o_rden; vh[5-i] = o_valid; bh[5-i] = o_busy;
    end
    n_checks++;
    if (rh !== 6'b011100) begin n_fail++; $display("FAIL single_rden: got %b want 011100", rh); end
    n_checks++;
    if (vh !== 6'b001110) begin n_fail++; $display("FAIL single_valid: got %b want 001110", vh); end
    n_checks++;
    if (bh !== 6'b011100) begin n_fail++; $display("FAIL single_busy: got %b want 011100", bh); end
    exp_q.push_back({1'b1, 1'b0, 32'hAAAA_000A});
    exp_q.push_back({1'b0, 1'b0, 32'hBBBB_000B});
    exp_q.push_back({1'b0, 1'b1, 32'hCCCC_000C});
    n_checks++;
    if (outq.size() != 3) begin
      n_fail++; $display("FAIL single_count: got %0d want 3", outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (outq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, outq[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if ({o_pkt, o_word} !== (STATS ? {32'd1, 32'd3} : 64'h0)) begin
      n_fail++; $display("FAIL single_cnt: got %0d/%0d", o_pkt, o_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] rh, vh, lh;
    int pops0;
    beat_t exp_q[$];
    outq.delete();
    pops0 = len_pops;
    dq.push_back(32'd1); dq.push_back(32'd2); dq.push_back(32'd3);
    lq.push_back(5'd2); lq.push_back(5'd1);
    refresh();
    for (int i = 0; i < 7; i++) begin
      tick();
      rh[6-i] = o_rden; vh[6-i] = o_valid; lh[6-i] = o_lenr;
    end
    n_checks++;
    if (rh !== 7'b0110100) begin n_fail++; $display("FAIL b2b_rden: got %b want 0110100", rh); end
    n_checks++;
    if (vh !== 7'b0011010) begin n_fail++; $display("FAIL b2b_valid: got %b want 0011010", vh); end
    n_checks++;
    if (lh !== 7'b1001000) begin n_fail++; $display("FAIL b2b_lenready: got %b want 1001000", lh); end
    n_checks++;
    if (len_pops - pops0 != 2) begin
      n_fail++; $display("FAIL b2b_lenpops: got %0d want 2", len_pops - pops0);
    end
    exp_q.push_back({1'b1, 1'b0, 32'd1});
    exp_q.push_back({1'b0, 1'b1, 32'd2});
    exp_q.push_back({1'b1, 1'b1, 32'd3});
    n_checks++;
    if (outq.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 3", outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (outq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, outq[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [34:0] prev;
    logic        prev_stall;
    int          stalls;
    beat_t       exp_q[$];
    outq.delete();
    stalls = 0; prev_stall = 1'b0; prev = '0;
    for (int i = 0; i < 4; i++) dq.push_back(32'h5000_0000 + i);
    lq.push_back(5'd4);
    refresh();
    for (int i = 0; i < 20; i++) begin
      m_ready_i = (i % 2 == 0);
      tick();
      if (prev_stall) begin
        stalls++;
        n_checks++;
        if ({o_valid, o_sop, o_last, o_data} !== prev) begin
          n_fail++; $display("FAIL stall_hold: got %h want %h", {o_valid, o_sop, o_last, o_data}, prev);
        end
      end
      n_checks++;
      if (o_rden && o_valid && !o_ready) begin
        n_fail++; $display("FAIL stall_rden: got rden=1 want 0 while stalled");
      end
      prev       = {o_valid, o_sop, o_last, o_data};
      prev_stall = o_valid && !o_ready;
    end
    m_ready_i = 1'b1;
    n_checks++;
    if (stalls < 1) begin n_fail++; $display("FAIL stall_seen: got %0d stalls want >0", stalls); end
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 0, i == 3, 32'h5000_0000 + i});
    n_checks++;
    if (outq.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d want 4", outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (outq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, outq[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    logic [5:0] eh, rh;
    outq.delete();
    lq.push_back(5'd0); lq.push_back(5'd1);
    dq.push_back(32'hDEAD_0001);
    refresh();
    for (int i = 0; i < 6; i++) begin
      tick();
      eh[5-i] = o_err; rh[5-i] = o_rden;
    end
    n_checks++;
    if (eh !== 6'b010000) begin n_fail++; $display("FAIL zero_err: got %b want 010000", eh); end
    n_checks++;
    if (rh !== 6'b001000) begin n_fail++; $display("FAIL zero_rden: got %b want 001000", rh); end
    n_checks++;
    if (outq.size() != 1 || outq[0] !== {1'b1, 1'b1, 32'hDEAD_0001}) begin
      n_fail++; $display("FAIL zero_beat: got %0d beats head %h want 1 beat %h", outq.size(),
                         (outq.size() != 0) ? outq[0] : 34'h0, {1'b1, 1'b1, 32'hDEAD_0001});
    end
    n_checks++;
    if ({o_pkt, o_word} !== (STATS ? {32'd5, 32'd11} : 64'h0)) begin
      n_fail++; $display("FAIL zero_cnt: got %0d/%0d", o_pkt, o_word);
    end
  endtask

  task automatic test_underrun();
    beat_t exp_q[$];
    outq.delete();
    lq.push_back(5'd5);
    dq.push_back(32'hE000_0000); dq.push_back(32'hE000_0001);
    refresh();
    repeat (12) tick();
    n_checks++;
    if (outq.size() != 2 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL under_wait: got %0d beats busy=%b want 2 beats busy=1", outq.size(), o_busy);
    end
    for (int i = 2; i < 5; i++) dq.push_back(32'hE000_0000 + i);
    refresh();
    repeat (8) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 0, i == 4, 32'hE000_0000 + i});
    n_checks++;
    if (outq.size() != 5) begin
      n_fail++; $display("FAIL under_count: got %0d want 5", outq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (outq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL under_beat%0d: got %h want %h", i, outq[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL under_busy: got %b want 0", o_busy); end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL under_viol: got %0d protocol violations want 0", viol); end
  endtask

  task automatic test_reset_mid();
    lq.push_back(5'd4);
    for (int i = 0; i < 4; i++) dq.push_back(32'hF000_0000 + i);
    refresh();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    refresh();
    tick();
    n_checks++;
    if ({o_valid, o_sop, o_last, o_rden, o_lenr, o_busy, o_err} !== 7'b0 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b data %h want all 0",
               {o_valid, o_sop, o_last, o_rden, o_lenr, o_busy, o_err}, o_data);
    end
    n_checks++;
    if ({o_pkt, o_word} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_cnt0: got %0d/%0d want 0/0", o_pkt, o_word);
    end
    outq.delete();
    lq.push_back(5'd1);
    dq.push_back(32'h1234_5678);
    refresh();
    repeat (5) tick();
    n_checks++;
    if (outq.size() != 1 || outq[0] !== {1'b1, 1'b1, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rstmid_beat: got %0d beats head %h want 1 beat %h", outq.size(),
                         (outq.size() != 0) ? outq[0] : 34'h0, {1'b1, 1'b1, 32'h1234_5678});
    end
    n_checks++;
    if ({o_pkt, o_word} !== (STATS ? {32'd1, 32'd1} : 64'h0)) begin
      n_fail++; $display("FAIL rstmid_cnt1: got %0d/%0d", o_pkt, o_word);
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL final_viol: got %0d protocol violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_len_zero();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
